move_select_ctrl: RTL and testbench
===================================

# move_select_ctrl

Parametrised move-selection controller for the chess game-play path. It sits between the debounced key pulses and the move validator. It walks a cursor over a ROWS×COLS board, lets the active player pick a piece and a destination, and hands the candidate move to the validator over a req/done handshake. Unlike the fixed 8×8 controller, it adds:
- configurable board size, piece width and ownership split
- wrap or saturate cursor mode
- a cancel key and in-place reselection
- validator timeout
- automatic return to destination select after a rejected move

## Interface
Parameters:
- COLS, 8, board columns (2..16)
- ROWS, 8, board rows (2..16)
- PW, 4, piece code width
- EMPTY, 15, piece code for an empty square
- SPLIT, 5, codes 0..SPLIT belong to player 1; codes SPLIT+1..EMPTY-1 belong to player 0
- WRAP, 1, 1 = cursor wraps at edges, 0 = cursor saturates at edges
- TIMEOUT, 255, maximum cycles to wait for val_done (≥1)
- XW/YW, derived: $clog2(COLS) / $clog2(ROWS)

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset, asynchronous, active-low
- enable  in  1  chess screen active; when low, the FSM and all registers hold
- turn_en  in  1  high when this side's player equals the current player
- player  in  1  owning side (selects the ownership test)
- dir  in  1  1 = vertical cursor motion, 0 = horizontal
- key_minus, key_plus, key_enter, key_cancel  in  1 each  single-cycle key pulses
- board_in  in  ROWS*COLS*PW  stable board; square (r,c) at bits [(r*COLS+c)*PW +: PW]
- val_req  out  1  validator request (level)
- val_done  in  1  validator result strobe
- val_ok  in  1  move legal; sampled only with val_done
- disp_board  out  ROWS*COLS*PW  display board, same packing as board_in
- highlight  out  ROWS*COLS  cursor highlight, bit r*COLS+c
- move_packet  out  2*(XW+YW)  {src_x, src_y, dst_x, dst_y}
- moved  out  1  one-cycle pulse when a move is accepted
- rejected  out  1  one-cycle pulse on an illegal move or timeout
- state  out  3  FSM state, for debug

## Operation
- States: IDLE=0, PIECE_SEL=1, DEST_SEL=2, VALIDATE=3.
- **IDLE:** disp_board<=board_in. When turn_en is high: go to PIECE_SEL, cursor to (COLS/2-1, ROWS/2-1), src equal to the cursor.
- **Cursor motion** (PIECE_SEL and DEST_SEL only):
  - dir=1: key_minus moves y-1, key_plus moves y+1.
  - dir=0: key_minus moves x+1, key_plus moves x-1.
  - WRAP=1: modulo COLS/ROWS; valid for non-power-of-2 sizes, so COLS-1 +1 gives 0 and 0 -1 gives COLS-1.
  - WRAP=0: clamp to 0..COLS-1 / 0..ROWS-1.
- **Key priority per cycle:** enter > cancel > minus > plus. Lower-priority keys in the same cycle are ignored.
- **Ownership:** own(p) is true when p≠EMPTY and (player ? p≤SPLIT : p>SPLIT).
- **PIECE_SEL:**
  - disp_board<=board_in.
  - enter on own(cursor square): src<=cursor, sel<=piece code, go to DEST_SEL.
  - Enter on any other square is ignored.
  - cancel is ignored.
- **DEST_SEL:**
  - disp_board<=board_in with the src square set to EMPTY and the cursor square set to sel. The cursor overlay is applied last.
  - enter on own(cursor square): reselect in place (src and sel reload), stay in DEST_SEL. This includes the src square itself.
  - enter on any other square: val_req<=1, timer cleared, go to VALIDATE.
  - cancel: cursor<=src, go to PIECE_SEL.
- **VALIDATE:**
  - Cursor keys and cancel are ignored.
  - disp_board keeps the overlay.
  - Timer counts cycles from 0.
  - val_done with val_ok=1: moved pulse, val_req<=0, go to IDLE.
  - val_done with val_ok=0, or timer reaching TIMEOUT without val_done: rejected pulse, val_req<=0, cursor<=src, go to DEST_SEL.
  - val_done takes precedence over timeout in the same cycle.
- **highlight** is combinational: a single bit at the cursor when turn_en is high and state≠IDLE, otherwise all zero.
- **move_packet** is combinational from the src and cursor registers.
- **turn_en falling** in any non-IDLE state except VALIDATE: go to IDLE, with no pulse. In VALIDATE the handshake completes first.
- **enable low:** every register holds, including the timer. val_req stays at its value.

## Timing
- **Reset values:**
  - state=IDLE, cursor=(COLS/2-1, ROWS/2-1), src=cursor, sel=EMPTY
  - disp_board all EMPTY, val_req=0, moved=0, rejected=0, timer=0
- **Register latency:** all registered outputs update on the clock edge after the qualifying input. Key effect on the cursor, and therefore on highlight, is 1 cycle. disp_board lags the cursor by 1 cycle.
- **Validator handshake:**
  - val_req rises on the edge after enter.
  - val_done is ignored outside VALIDATE.
  - val_req falls on the edge that samples val_done. moved or rejected is high for exactly that following cycle.
  - Minimum enter-to-moved latency is 2 cycles, with val_done on the first VALIDATE cycle.
- **Timeout:** rejected asserts on the edge where the timer equals TIMEOUT. That is TIMEOUT+1 cycles after val_req rises.
- **Reset mid-handshake:** val_req drops immediately and asynchronously. No pulse is emitted.

## Test plan
- **Wrap:** reset, turn_en=1, dir=0, WRAP=1, COLS=8. Press key_minus 5 times: x goes 3→4→5→6→7→0, highlight bit 3*8+0 set. With WRAP=0 the same stimulus saturates at x=7.
- **Ownership:** player=1, board_in(3,3)=2. Enter gives DEST_SEL, sel=2. Repeat with code 9 or EMPTY: state stays PIECE_SEL.
- **Legal move:** select (3,3); move to (3,5) with dir=1 plus×2; enter. val_req next cycle; val_done=1, val_ok=1 two cycles later → moved pulses once, move_packet={3,3,3,5}, state IDLE.
- **Reject and timeout:** val_ok=0 → rejected pulse, cursor back at (3,3), state DEST_SEL. With TIMEOUT=4 and no val_done → rejected exactly 5 cycles after val_req rises.
- **Cancel/reselect:** in DEST_SEL, enter on another own piece at (1,3) → src=(1,3) with no val_req. cancel → PIECE_SEL with the cursor at (1,3).
- **Freeze/reset:** drop enable mid-VALIDATE for 10 cycles → timer and state hold. Assert reset_n low while val_req=1 → all outputs return to reset values with no pulses.

Source files
------------

// File: rtl/move_select_ctrl.sv
// Move-selection controller: walks a cursor over a ROWS x COLS board, picks a piece and a
// destination for the active player, and hands the candidate move to a validator over req/done.
module move_select_ctrl #(
    parameter int COLS    = 8,
    parameter int ROWS    = 8,
    parameter int PW      = 4,
    parameter int EMPTY   = 15,
    parameter int SPLIT   = 5,
    parameter int WRAP    = 1,
    parameter int TIMEOUT = 255,
    localparam int XW     = $clog2(COLS),
    localparam int YW     = $clog2(ROWS),
    localparam int BW     = ROWS * COLS * PW
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    enable,
    input  logic                    turn_en,
    input  logic                    player,
    input  logic                    dir,
    input  logic                    key_minus,
    input  logic                    key_plus,
    input  logic                    key_enter,
    input  logic                    key_cancel,
    input  logic [BW-1:0]           board_in,
    output logic                    val_req,
    input  logic                    val_done,
    input  logic                    val_ok,
    output logic [BW-1:0]           disp_board,
    output logic [ROWS*COLS-1:0]    highlight,
    output logic [2*(XW+YW)-1:0]    move_packet,
    output logic                    moved,
    output logic                    rejected,
    output logic [2:0]              state
);

    localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PIECE_SEL = 3'd1,
        DEST_SEL  = 3'd2,
        VALIDATE  = 3'd3
    } state_t;

    state_t          state_q, state_d;
    logic [XW-1:0]   cur_x_q, cur_x_d, src_x_q, src_x_d, mv_x;
    logic [YW-1:0]   cur_y_q, cur_y_d, src_y_q, src_y_d, mv_y;
    logic [PW-1:0]   sel_q, sel_d, cur_piece;
    logic [BW-1:0]   disp_q, disp_d;
    logic            val_req_q, val_req_d, moved_q, moved_d, rejected_q, rejected_d;
    logic [TW-1:0]   timer_q, timer_d;
    int              cur_idx, src_idx;

    // Next position along one axis; the edge case either wraps (works for non-power-of-2 sizes) or clamps.
    function automatic int step_pos(input int v, input int lim, input logic up);
        if (up) begin
            if (v == lim - 1) return (WRAP != 0) ? 0 : v;
            return v + 1;
        end
        if (v == 0) return (WRAP != 0) ? lim - 1 : 0;
        return v - 1;
    endfunction

    function automatic logic is_own(input logic [PW-1:0] p, input logic side);
        return (p != PW'(EMPTY)) && (side ? (p <= PW'(SPLIT)) : (p > PW'(SPLIT)));
    endfunction

    assign cur_idx   = int'(cur_y_q) * COLS + int'(cur_x_q);
    assign src_idx   = int'(src_y_q) * COLS + int'(src_x_q);
    assign cur_piece = board_in[cur_idx*PW +: PW];

    // Horizontal keys are mirrored relative to vertical: minus moves right, plus moves left.
    always_comb begin
        mv_x = cur_x_q;
        mv_y = cur_y_q;
        if (key_minus) begin
            if (dir) mv_y = YW'(step_pos(int'(cur_y_q), ROWS, 1'b0));
            else     mv_x = XW'(step_pos(int'(cur_x_q), COLS, 1'b1));
        end else if (key_plus) begin
            if (dir) mv_y = YW'(step_pos(int'(cur_y_q), ROWS, 1'b1));
            else     mv_x = XW'(step_pos(int'(cur_x_q), COLS, 1'b0));
        end
    end

    // NOTE: every signal driven here gets a default first, so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        cur_x_d    = cur_x_q;
        cur_y_d    = cur_y_q;
        src_x_d    = src_x_q;
        src_y_d    = src_y_q;
        sel_d      = sel_q;
        val_req_d  = val_req_q;
        timer_d    = timer_q;
        moved_d    = 1'b0;
        rejected_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (turn_en) begin
                    state_d = PIECE_SEL;
                    cur_x_d = XW'(COLS/2 - 1);
                    cur_y_d = YW'(ROWS/2 - 1);
                    src_x_d = XW'(COLS/2 - 1);
                    src_y_d = YW'(ROWS/2 - 1);
                end
            end
            PIECE_SEL: begin
                if (!turn_en) begin
                    state_d = IDLE;
                end else if (key_enter) begin
                    if (is_own(cur_piece, player)) begin
                        src_x_d = cur_x_q;
                        src_y_d = cur_y_q;
                        sel_d   = cur_piece;
                        state_d = DEST_SEL;
                    end
                end else if (!key_cancel) begin
                    cur_x_d = mv_x;
                    cur_y_d = mv_y;
                end
            end
            DEST_SEL: begin
                if (!turn_en) begin
                    state_d = IDLE;
                end else if (key_enter) begin
                    if (is_own(cur_piece, player)) begin
                        src_x_d = cur_x_q;
                        src_y_d = cur_y_q;
                        sel_d   = cur_piece;
                    end else begin
                        val_req_d = 1'b1;
                        timer_d   = '0;
                        state_d   = VALIDATE;
                    end
                end else if (key_cancel) begin
                    cur_x_d = src_x_q;
                    cur_y_d = src_y_q;
                    state_d = PIECE_SEL;
                end else begin
                    cur_x_d = mv_x;
                    cur_y_d = mv_y;
                end
            end
            VALIDATE: begin
                // A result strobe wins over an expiring timer in the same cycle.
                if (val_done && val_ok) begin
                    moved_d   = 1'b1;
                    val_req_d = 1'b0;
                    state_d   = IDLE;
                end else if (val_done || (timer_q == TW'(TIMEOUT))) begin
                    rejected_d = 1'b1;
                    val_req_d  = 1'b0;
                    cur_x_d    = src_x_q;
                    cur_y_d    = src_y_q;
                    state_d    = DEST_SEL;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Destination preview: lift the piece off src, then drop it at the cursor (cursor wins if equal).
    always_comb begin
        disp_d = board_in;
        if (state_q == DEST_SEL || state_q == VALIDATE) begin
            disp_d[src_idx*PW +: PW] = PW'(EMPTY);
            disp_d[cur_idx*PW +: PW] = sel_q;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= IDLE;
            cur_x_q    <= XW'(COLS/2 - 1);
            cur_y_q    <= YW'(ROWS/2 - 1);
            src_x_q    <= XW'(COLS/2 - 1);
            src_y_q    <= YW'(ROWS/2 - 1);
            sel_q      <= PW'(EMPTY);
            disp_q     <= {(ROWS*COLS){PW'(EMPTY)}};
            val_req_q  <= 1'b0;
            moved_q    <= 1'b0;
            rejected_q <= 1'b0;
            timer_q    <= '0;
        end else if (enable) begin
            state_q    <= state_d;
            cur_x_q    <= cur_x_d;
            cur_y_q    <= cur_y_d;
            src_x_q    <= src_x_d;
            src_y_q    <= src_y_d;
            sel_q      <= sel_d;
            disp_q     <= disp_d;
            val_req_q  <= val_req_d;
            moved_q    <= moved_d;
            rejected_q <= rejected_d;
            timer_q    <= timer_d;
        end
    end

    always_comb begin
        highlight = '0;
        if (turn_en && state_q != IDLE) highlight[cur_idx] = 1'b1;
    end

    assign move_packet = {src_x_q, src_y_q, cur_x_q, cur_y_q};
    assign disp_board  = disp_q;
    assign val_req     = val_req_q;
    assign moved       = moved_q;
    assign rejected    = rejected_q;
    assign state       = state_q;

endmodule

// File: tb/tb_move_select_ctrl.sv
// Directed bench for move_select_ctrl: a wrapping 8x8 instance with a short validator timeout,
// plus a saturating twin driven by the same stimulus for the edge-clamp case.
module tb_move_select_ctrl;

    localparam int COLS = 8;
    localparam int ROWS = 8;
    localparam int PW   = 4;
    localparam int BW   = ROWS * COLS * PW;

    logic clk = 1'b0;
    logic reset_n = 1'b0, enable = 1'b0, turn_en = 1'b0, player = 1'b0, dir = 1'b0;
    logic key_minus = 1'b0, key_plus = 1'b0, key_enter = 1'b0, key_cancel = 1'b0;
    logic val_done = 1'b0, val_ok = 1'b0;
    logic [BW-1:0] board_in;

    logic [BW-1:0] disp_board, disp_board_s;
    logic [63:0]   highlight, highlight_s;
    logic [11:0]   move_packet, move_packet_s;
    logic [2:0]    state, state_s;
    logic          val_req, moved, rejected, val_req_s, moved_s, rejected_s;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    move_select_ctrl #(.COLS(COLS), .ROWS(ROWS), .PW(PW), .EMPTY(15), .SPLIT(5),
                       .WRAP(1), .TIMEOUT(4)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .turn_en(turn_en), .player(player),
        .dir(dir), .key_minus(key_minus), .key_plus(key_plus), .key_enter(key_enter),
        .key_cancel(key_cancel), .board_in(board_in), .val_req(val_req), .val_done(val_done),
        .val_ok(val_ok), .disp_board(disp_board), .highlight(highlight),
        .move_packet(move_packet), .moved(moved), .rejected(rejected), .state(state)
    );

    move_select_ctrl #(.COLS(COLS), .ROWS(ROWS), .PW(PW), .EMPTY(15), .SPLIT(5),
                       .WRAP(0), .TIMEOUT(4)) dut_sat (
        .clk(clk), .reset_n(reset_n), .enable(enable), .turn_en(turn_en), .player(player),
        .dir(dir), .key_minus(key_minus), .key_plus(key_plus), .key_enter(key_enter),
        .key_cancel(key_cancel), .board_in(board_in), .val_req(val_req_s), .val_done(val_done),
        .val_ok(val_ok), .disp_board(disp_board_s), .highlight(highlight_s),
        .move_packet(move_packet_s), .moved(moved_s), .rejected(rejected_s), .state(state_s)
    );

    task automatic check(input string tag, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic m, input logic p, input logic e, input logic c);
        key_minus = m; key_plus = p; key_enter = e; key_cancel = c;
        step();
        key_minus = 1'b0; key_plus = 1'b0; key_enter = 1'b0; key_cancel = 1'b0;
    endtask

    task automatic set_sq(input int r, input int c, input logic [3:0] v);
        board_in[(r*COLS + c)*PW +: PW] = v;
    endtask

    function automatic logic [3:0] sq(input logic [BW-1:0] b, input int r, input int c);
        return b[(r*COLS + c)*PW +: PW];
    endfunction

    function automatic logic [63:0] hl(input int x, input int y);
        return 64'd1 << (y*COLS + x);
    endfunction

    function automatic logic [11:0] mp(input int sx, input int sy, input int dx, input int dy);
        return {3'(sx), 3'(sy), 3'(dx), 3'(dy)};
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        board_in = '1;
        set_sq(1, 3, 4'd4);
        set_sq(3, 3, 4'd9);

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_state", state, 3'd0);
        check("rst_val_req", val_req, 1'b0);
        check("rst_pulses", {moved, rejected}, 2'b00);
        check("rst_highlight", highlight, 64'd0);
        check("rst_disp", disp_board, {BW{1'b1}});
        check("rst_packet", move_packet, mp(3, 3, 3, 3));

        reset_n = 1'b1; enable = 1'b1; player = 1'b1; dir = 1'b0; turn_en = 1'b1;
        step();
        check("enter_piece_sel", state, 3'd1);
        check("center_highlight", highlight, hl(3, 3));

        // Horizontal minus moves x+1: wraps 7->0 on one instance, sticks at 7 on the other
        for (int i = 0; i < 4; i++) press(1'b1, 1'b0, 1'b0, 1'b0);
        check("x_at_7_wrap", highlight, hl(7, 3));
        check("x_at_7_sat", highlight_s, hl(7, 3));
        press(1'b1, 1'b0, 1'b0, 1'b0);
        check("x_wrap_to_0", highlight, hl(0, 3));
        check("x_saturate", highlight_s, hl(7, 3));
        check("packet_wrap", move_packet, mp(3, 3, 0, 3));

        // Turn loss returns to IDLE silently; regaining it recentres the cursor
        turn_en = 1'b0;
        step();
        check("turn_drop_idle", state, 3'd0);
        check("turn_drop_no_pulse", {moved, rejected}, 2'b00);
        check("turn_drop_no_hl", highlight, 64'd0);
        turn_en = 1'b1;
        step();
        check("recenter_state", state, 3'd1);
        check("recenter_hl", highlight, hl(3, 3));

        // Ownership: code 9 and EMPTY are not player 1's; code 2 is
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("enter_foreign", state, 3'd1);
        set_sq(3, 3, 4'd15);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("enter_empty", state, 3'd1);
        set_sq(3, 3, 4'd2);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("enter_own", state, 3'd2);
        check("disp_piece_sel", sq(disp_board, 3, 3), 4'd2);

        // Overlay follows the cursor one cycle later
        dir = 1'b1;
        press(1'b0, 1'b1, 1'b0, 1'b0);
        check("y_plus_hl", highlight, hl(3, 4));
        step();
        check("overlay_src_empty", sq(disp_board, 3, 3), 4'd15);
        check("overlay_cursor_sel", sq(disp_board, 4, 3), 4'd2);

        // Legal move with val_done on the second VALIDATE cycle
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("validate_state", state, 3'd3);
        check("val_req_rise", val_req, 1'b1);
        check("packet_legal", move_packet, mp(3, 3, 3, 5));
        step();
        check("wait_no_moved", moved, 1'b0);
        check("validate_overlay", sq(disp_board, 5, 3), 4'd2);
        val_done = 1'b1; val_ok = 1'b1;
        step();
        val_done = 1'b0; val_ok = 1'b0;
        check("moved_pulse", {moved, rejected}, 2'b10);
        check("val_req_fall", val_req, 1'b0);
        check("moved_idle", state, 3'd0);
        check("moved_packet", move_packet, mp(3, 3, 3, 5));
        step();
        check("moved_one_cycle", moved, 1'b0);
        check("reenter_piece_sel", state, 3'd1);

        // Rejected move returns to DEST_SEL with the cursor back on src
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("reject_validate", state, 3'd3);
        val_done = 1'b1; val_ok = 1'b0;
        step();
        val_done = 1'b0;
        check("reject_pulse", {moved, rejected}, 2'b01);
        check("reject_val_req", val_req, 1'b0);
        check("reject_dest_sel", state, 3'd2);
        check("reject_cursor", highlight, hl(3, 3));
        step();
        check("reject_one_cycle", rejected, 1'b0);

        // Timeout: rejected exactly TIMEOUT+1 = 5 cycles after val_req rises
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("to_val_req", val_req, 1'b1);
        for (int c = 1; c <= 4; c++) begin
            step();
            check($sformatf("to_early_%0d", c), rejected, 1'b0);
        end
        step();
        check("to_reject", rejected, 1'b1);
        check("to_state", state, 3'd2);
        check("to_val_req_fall", val_req, 1'b0);

        // val_done outside VALIDATE has no effect
        val_done = 1'b1; val_ok = 1'b1;
        step();
        val_done = 1'b0; val_ok = 1'b0;
        check("done_ignored_moved", moved, 1'b0);
        check("done_ignored_state", state, 3'd2);

        // Reselect in place, then cancel (with a simultaneous minus that must lose)
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("reselect_state", state, 3'd2);
        check("reselect_no_req", val_req, 1'b0);
        check("reselect_packet", move_packet, mp(3, 1, 3, 1));
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b1, 1'b0, 1'b0, 1'b1);
        check("cancel_state", state, 3'd1);
        check("cancel_cursor", highlight, hl(3, 1));

        // Freeze mid-VALIDATE: timer holds, so two more cycles still pass before the timeout
        press(1'b0, 1'b0, 1'b1, 1'b0);
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        step();
        step();
        enable = 1'b0;
        for (int c = 0; c < 10; c++) begin
            step();
            check($sformatf("freeze_no_rej_%0d", c), rejected, 1'b0);
        end
        check("freeze_state", state, 3'd3);
        check("freeze_val_req", val_req, 1'b1);
        enable = 1'b1;
        step();
        check("resume_1", rejected, 1'b0);
        step();
        check("resume_2", rejected, 1'b0);
        step();
        check("resume_timeout", rejected, 1'b1);

        // Asynchronous reset during the handshake
        press(1'b0, 1'b1, 1'b0, 1'b0);
        press(1'b0, 1'b0, 1'b1, 1'b0);
        check("pre_reset_req", val_req, 1'b1);
        reset_n = 1'b0;
        #1;
        check("arst_val_req", val_req, 1'b0);
        check("arst_state", state, 3'd0);
        check("arst_pulses", {moved, rejected}, 2'b00);
        check("arst_highlight", highlight, 64'd0);
        check("arst_disp", disp_board, {BW{1'b1}});
        check("arst_packet", move_packet, mp(3, 3, 3, 3));
        step();
        check("arst_hold_pulses", {moved, rejected}, 2'b00);
        reset_n = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
